// File: rtl/ip_dispatch_pkg.sv
// Shared types and constants for the IP protocol dispatcher.
package ip_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_DROP
    } state_t;

    localparam logic [7:0] PROTO_ICMP = 8'h01;
    localparam logic [7:0] PROTO_TCP  = 8'h06;
    localparam logic [7:0] PROTO_UDP  = 8'h11;

    // Channel-select width; a single channel still gets a 1-bit index.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ip_dispatch_match.sv
// Priority protocol matcher: lowest enabled channel whose protocol equals proto wins.
module ip_dispatch_match
    import ip_dispatch_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = sel_width(NUM_CH)
) (
    input  logic [7:0]          proto,
    input  logic [8*NUM_CH-1:0] cfg_proto,
    input  logic [NUM_CH-1:0]   cfg_en,
    output logic                hit,
    output logic [SEL_W-1:0]    sel
);

    // Scan from the top so the lowest matching index is written last.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cfg_en[i] && (cfg_proto[i*8 +: 8] == proto)) begin
                hit = 1'b1;
                sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/ip_proto_dispatch.sv
// Routes IP header + payload frames to one of NUM_CH channels by protocol number.
// Define IP_DISPATCH_STATS_EN to build the per-channel frame and drop counters.
module ip_proto_dispatch
    import ip_dispatch_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,

    input  logic                        s_hdr_valid,
    output logic                        s_hdr_ready,
    input  logic [7:0]                  s_ip_protocol,
    input  logic [15:0]                 s_ip_length,
    input  logic [31:0]                 s_ip_source_ip,
    input  logic [31:0]                 s_ip_dest_ip,

    input  logic [DATA_WIDTH-1:0]       s_tdata,
    input  logic                        s_tvalid,
    output logic                        s_tready,
    input  logic                        s_tlast,
    input  logic                        s_tuser,

    output logic [NUM_CH-1:0]           m_hdr_valid,
    input  logic [NUM_CH-1:0]           m_hdr_ready,
    output logic [7:0]                  m_ip_protocol,
    output logic [15:0]                 m_ip_length,
    output logic [31:0]                 m_ip_source_ip,
    output logic [31:0]                 m_ip_dest_ip,

    output logic [DATA_WIDTH-1:0]       m_tdata,
    output logic [NUM_CH-1:0]           m_tvalid,
    input  logic [NUM_CH-1:0]           m_tready,
    output logic                        m_tlast,
    output logic                        m_tuser,

    input  logic [8*NUM_CH-1:0]         cfg_proto,
    input  logic [NUM_CH-1:0]           cfg_en,

    input  logic                        stat_clr,
    output logic [CNT_WIDTH*NUM_CH-1:0] stat_frames,
    output logic [CNT_WIDTH-1:0]        stat_drops
);

    localparam int SEL_W = sel_width(NUM_CH);

    state_t             state;
    logic [SEL_W-1:0]   sel_q;
    logic [NUM_CH-1:0]  hdr_vld_q;
    logic               match_hit;
    logic [SEL_W-1:0]   match_sel;
    logic               hdr_accept;
    logic               beat_last;

    ip_dispatch_match #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_match (
        .proto     (s_ip_protocol),
        .cfg_proto (cfg_proto),
        .cfg_en    (cfg_en),
        .hit       (match_hit),
        .sel       (match_sel)
    );

    assign s_hdr_ready = (state == ST_IDLE);
    assign hdr_accept  = s_hdr_ready && s_hdr_valid;
    assign beat_last   = s_tvalid && s_tready && s_tlast;
    assign m_hdr_valid = hdr_vld_q;

    assign m_tdata = s_tdata;
    assign m_tlast = s_tlast;
    assign m_tuser = s_tuser;

    // Payload steering is combinational so a beat costs no extra cycle.
    always_comb begin
        m_tvalid = '0;
        s_tready = 1'b0;
        case (state)
            ST_PAYLOAD: begin
                m_tvalid[sel_q] = s_tvalid;
                s_tready        = m_tready[sel_q];
            end
            ST_DROP:    s_tready = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= ST_IDLE;
            sel_q          <= '0;
            hdr_vld_q      <= '0;
            m_ip_protocol  <= '0;
            m_ip_length    <= '0;
            m_ip_source_ip <= '0;
            m_ip_dest_ip   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_hdr_valid) begin
                        m_ip_protocol  <= s_ip_protocol;
                        m_ip_length    <= s_ip_length;
                        m_ip_source_ip <= s_ip_source_ip;
                        m_ip_dest_ip   <= s_ip_dest_ip;
                        sel_q          <= match_sel;
                        if (match_hit) begin
                            state     <= ST_HDR;
                            hdr_vld_q <= NUM_CH'(1) << match_sel;
                        end else begin
                            state     <= ST_DROP;
                        end
                    end
                end
                ST_HDR: begin
                    if (m_hdr_ready[sel_q]) begin
                        state     <= ST_PAYLOAD;
                        hdr_vld_q <= '0;
                    end
                end
                ST_PAYLOAD: if (beat_last) state <= ST_IDLE;
                ST_DROP:    if (beat_last) state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

`ifdef IP_DISPATCH_STATS_EN
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] frames_q;
    logic [CNT_WIDTH-1:0]             drops_q;
    logic                             frame_inc;
    logic                             drop_inc;

    assign frame_inc = (state == ST_PAYLOAD) && beat_last;
    assign drop_inc  = hdr_accept && !match_hit;

    // Clear has priority; increments stop at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frames_q <= '0;
            drops_q  <= '0;
        end else if (stat_clr) begin
            frames_q <= '0;
            drops_q  <= '0;
        end else begin
            if (drop_inc && (drops_q != '1))
                drops_q <= drops_q + CNT_WIDTH'(1);
            if (frame_inc && (frames_q[sel_q] != '1))
                frames_q[sel_q] <= frames_q[sel_q] + CNT_WIDTH'(1);
        end
    end

    assign stat_frames = frames_q;
    assign stat_drops  = drops_q;
`else
    logic unused_stat;

    assign unused_stat = &{1'b0, stat_clr, hdr_accept};
    assign stat_frames = '0;
    assign stat_drops  = '0;
`endif

endmodule

// File: tb/tb_ip_proto_dispatch.sv
// Randomized self-checking bench for ip_proto_dispatch against a frame-level model.
module tb_ip_proto_dispatch;

    localparam int NC = 4;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              s_hdr_valid;
    logic              s_hdr_ready;
    logic [7:0]        s_ip_protocol;
    logic [15:0]       s_ip_length;
    logic [31:0]       s_ip_source_ip;
    logic [31:0]       s_ip_dest_ip;
    logic [DW-1:0]     s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic              s_tlast;
    logic              s_tuser;
    logic [NC-1:0]     m_hdr_valid;
    logic [NC-1:0]     m_hdr_ready;
    logic [7:0]        m_ip_protocol;
    logic [15:0]       m_ip_length;
    logic [31:0]       m_ip_source_ip;
    logic [31:0]       m_ip_dest_ip;
    logic [DW-1:0]     m_tdata;
    logic [NC-1:0]     m_tvalid;
    logic [NC-1:0]     m_tready;
    logic              m_tlast;
    logic              m_tuser;
    logic [8*NC-1:0]   cfg_proto;
    logic [NC-1:0]     cfg_en;
    logic              stat_clr;
    logic [CW*NC-1:0]  stat_frames;
    logic [CW-1:0]     stat_drops;

    int checks = 0;
    int errors = 0;
    int cfg_p [NC];
    bit cfg_e [NC];
    int exp_frames [NC];
    int exp_drops;

    always #5 i_clk = ~i_clk;

    ip_proto_dispatch #(.NUM_CH(NC), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
        .s_ip_protocol(s_ip_protocol), .s_ip_length(s_ip_length),
        .s_ip_source_ip(s_ip_source_ip), .s_ip_dest_ip(s_ip_dest_ip),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tlast(s_tlast), .s_tuser(s_tuser),
        .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready),
        .m_ip_protocol(m_ip_protocol), .m_ip_length(m_ip_length),
        .m_ip_source_ip(m_ip_source_ip), .m_ip_dest_ip(m_ip_dest_ip),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_tuser(m_tuser),
        .cfg_proto(cfg_proto), .cfg_en(cfg_en),
        .stat_clr(stat_clr), .stat_frames(stat_frames), .stat_drops(stat_drops)
    );

    function automatic int ref_sel(input int proto);
        for (int c = 0; c < NC; c++)
            if (cfg_e[c] && cfg_p[c] == proto) return c;
        return -1;
    endfunction

    function automatic logic [NC-1:0] oh(input int c);
        logic [NC-1:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    function automatic int want_frames(input int c);
`ifdef IP_DISPATCH_STATS_EN
        return exp_frames[c];
`else
        return 0;
`endif
    endfunction

    function automatic int want_drops();
`ifdef IP_DISPATCH_STATS_EN
        return exp_drops;
`else
        return 0;
`endif
    endfunction

    task automatic apply_cfg();
        for (int c = 0; c < NC; c++) begin
            cfg_proto[c*8 +: 8] = 8'(cfg_p[c]);
            cfg_en[c] = cfg_e[c];
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NC; c++) exp_frames[c] = 0;
        exp_drops = 0;
    endtask

    task automatic check_stats(input string tag);
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (int'(stat_frames[c*CW +: CW]) != want_frames(c)) begin
                errors++;
                $display("FAIL %s stat_frames[%0d] got %0d want %0d", tag, c,
                         stat_frames[c*CW +: CW], want_frames(c));
            end
        end
        checks++;
        if (int'(stat_drops) != want_drops()) begin
            errors++;
            $display("FAIL %s stat_drops got %0d want %0d", tag, stat_drops, want_drops());
        end
    endtask

    // Drives one complete frame and checks routing, payload and counters.
    task automatic send_frame(input int proto, input int len, input bit bp,
                              input bit clr_last, input bit chg_cfg);
        int exp;
        int i;
        int bound;
        int w;
        int bad;
        bit beat;
        logic [15:0] f_len;
        logic [31:0] f_src;
        logic [31:0] f_dst;
        logic [7:0] data [$];
        logic [7:0] recv [$];
        exp = ref_sel(proto);
        for (int k = 0; k < len; k++) data.push_back(8'($urandom));
        f_len = 16'($urandom);
        f_src = $urandom;
        f_dst = $urandom;

        s_hdr_valid = 1'b1;
        s_ip_protocol = 8'(proto);
        s_ip_length = f_len;
        s_ip_source_ip = f_src;
        s_ip_dest_ip = f_dst;
        #1;
        checks++;
        if (s_hdr_ready !== 1'b1) begin
            errors++;
            $display("FAIL hdr_ready_idle got %b want 1", s_hdr_ready);
        end
        @(posedge i_clk); #1;
        s_hdr_valid = 1'b0;
        s_ip_protocol = 8'($urandom);
        s_ip_length = 16'($urandom);
        s_ip_source_ip = $urandom;
        s_ip_dest_ip = $urandom;
        if (chg_cfg && exp >= 0) begin
            cfg_e[exp] = 1'b0;
            apply_cfg();
        end
        if (exp < 0) exp_drops = (exp_drops + 1 > CMAX) ? CMAX : exp_drops + 1;

        checks++;
        if (m_ip_protocol !== 8'(proto) || m_ip_length !== f_len ||
            m_ip_source_ip !== f_src || m_ip_dest_ip !== f_dst) begin
            errors++;
            $display("FAIL hdr_fields got %h/%h/%h/%h want %h/%h/%h/%h", m_ip_protocol,
                     m_ip_length, m_ip_source_ip, m_ip_dest_ip, 8'(proto), f_len, f_src, f_dst);
        end

        if (exp >= 0) begin
            w = $urandom_range(0, 2);
            for (int k = 0; k <= w; k++) begin
                m_hdr_ready = 4'($urandom) & ~oh(exp);
                if (k == w) m_hdr_ready[exp] = 1'b1;
                #1;
                checks++;
                if (m_hdr_valid !== oh(exp) || m_tvalid !== '0 || s_tready !== 1'b0) begin
                    errors++;
                    $display("FAIL hdr_state hv=%b tv=%b tr=%b want hv=%b tv=0 tr=0",
                             m_hdr_valid, m_tvalid, s_tready, oh(exp));
                end
                @(posedge i_clk); #1;
            end
            m_hdr_ready = '0;
        end else begin
            checks++;
            if (m_hdr_valid !== '0) begin
                errors++;
                $display("FAIL drop_hdr_valid got %b want 0", m_hdr_valid);
            end
        end

        i = 0;
        bound = 0;
        while (i < len && bound < len * 40 + 40) begin
            s_tvalid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_tdata = data[i];
            s_tlast = (i == len - 1);
            s_tuser = 1'($urandom);
            m_tready = bp ? 4'($urandom) : '1;
            stat_clr = clr_last && (i == len - 1);
            #1;
            checks++;
            if (exp >= 0) begin
                if (m_tvalid !== (s_tvalid ? oh(exp) : '0) || s_tready !== m_tready[exp] ||
                    m_tdata !== s_tdata || m_tlast !== s_tlast || m_tuser !== s_tuser) begin
                    errors++;
                    $display("FAIL payload_route tv=%b tr=%b d=%h want tv=%b tr=%b d=%h",
                             m_tvalid, s_tready, m_tdata, (s_tvalid ? oh(exp) : '0),
                             m_tready[exp], s_tdata);
                end
                beat = s_tvalid && m_tready[exp];
                if (beat) recv.push_back(m_tdata);
            end else begin
                if (m_tvalid !== '0 || s_tready !== 1'b1) begin
                    errors++;
                    $display("FAIL drop_payload tv=%b tr=%b want tv=0 tr=1", m_tvalid, s_tready);
                end
                beat = s_tvalid;
            end
            @(posedge i_clk); #1;
            if (beat) i++;
            bound++;
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        stat_clr = 1'b0;
        m_tready = '0;

        checks++;
        if (i != len) begin
            errors++;
            $display("FAIL payload_timeout beats got %0d want %0d", i, len);
        end
        if (exp >= 0) begin
            bad = (recv.size() != len) ? 1 : 0;
            for (int k = 0; k < recv.size() && k < len; k++)
                if (recv[k] !== data[k]) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL byte_order got %0d bytes %0d wrong want %0d bytes in order",
                         recv.size(), bad, len);
            end
        end

        if (clr_last) model_clear();
        else if (exp >= 0) exp_frames[exp] = (exp_frames[exp] + 1 > CMAX) ? CMAX : exp_frames[exp] + 1;

        checks++;
        if (s_hdr_ready !== 1'b1) begin
            errors++;
            $display("FAIL back_to_idle hdr_ready got %b want 1", s_hdr_ready);
        end
        check_stats("frame");
        if (chg_cfg && exp >= 0) begin
            cfg_e[exp] = 1'b1;
            apply_cfg();
        end
    endtask

    task automatic set_default_cfg();
        cfg_p[0] = 8'h01; cfg_p[1] = 8'h11; cfg_p[2] = 8'h06; cfg_p[3] = 8'h11;
        for (int c = 0; c < NC; c++) cfg_e[c] = 1'b1;
        apply_cfg();
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        s_hdr_valid = 1'b0; s_ip_protocol = '0; s_ip_length = '0;
        s_ip_source_ip = '0; s_ip_dest_ip = '0;
        s_tdata = '0; s_tvalid = 1'b1; s_tlast = 1'b0; s_tuser = 1'b0;
        m_hdr_ready = '1; m_tready = '1; stat_clr = 1'b0;
        set_default_cfg();
        model_clear();
        #12;
        checks++;
        if (m_hdr_valid !== '0 || m_tvalid !== '0 || s_tready !== 1'b0 ||
            m_ip_protocol !== '0 || m_ip_length !== '0 || m_ip_source_ip !== '0 ||
            m_ip_dest_ip !== '0) begin
            errors++;
            $display("FAIL reset_outputs hv=%b tv=%b tr=%b proto=%h want all 0",
                     m_hdr_valid, m_tvalid, s_tready, m_ip_protocol);
        end
        check_stats("reset");
        s_tvalid = 1'b0; m_hdr_ready = '0; m_tready = '0;
        @(negedge i_clk); i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        checks++;
        if (s_hdr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release hdr_ready got %b want 1", s_hdr_ready);
        end
    endtask

    task automatic test_route();
        set_default_cfg();
        send_frame(8'h11, 4, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_drop();
        send_frame(8'h2F, 10, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_disabled();
        cfg_e[1] = 1'b0;
        apply_cfg();
        send_frame(8'h11, 5, 1'b0, 1'b0, 1'b0);
        set_default_cfg();
    endtask

    task automatic test_backpressure();
        for (int n = 0; n < 4; n++) send_frame(8'h06, 12, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        send_frame(8'h06, 1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h01, 1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h7E, 1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_cfg_change();
        send_frame(8'h11, 6, 1'b0, 1'b0, 1'b1);
        send_frame(8'h01, 3, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        s_hdr_valid = 1'b1; s_ip_protocol = 8'h06;
        @(posedge i_clk); #1;
        s_hdr_valid = 1'b0;
        m_hdr_ready = '1;
        @(posedge i_clk); #1;
        s_tvalid = 1'b1; s_tlast = 1'b0; m_tready = '1;
        @(posedge i_clk); #1;
        i_rst_n = 1'b0;
        #1;
        model_clear();
        checks++;
        if (m_hdr_valid !== '0 || m_tvalid !== '0 || s_tready !== 1'b0 ||
            m_ip_protocol !== '0 || m_ip_length !== '0 || m_ip_source_ip !== '0 ||
            m_ip_dest_ip !== '0) begin
            errors++;
            $display("FAIL reset_mid hv=%b tv=%b tr=%b proto=%h want all 0",
                     m_hdr_valid, m_tvalid, s_tready, m_ip_protocol);
        end
        check_stats("reset_mid");
        s_tvalid = 1'b0; m_hdr_ready = '0; m_tready = '0;
        @(negedge i_clk); i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        checks++;
        if (s_hdr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_release hdr_ready got %b want 1", s_hdr_ready);
        end
        send_frame(8'h11, 5, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 17; n++) send_frame(8'h01, 1, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 17; n++) send_frame(8'h33, 1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h11, 2, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        int pool [5];
        pool[0] = 8'h01; pool[1] = 8'h06; pool[2] = 8'h11; pool[3] = 8'h2F;
        for (int n = 0; n < 20; n++) begin
            pool[4] = $urandom_range(0, 255);
            for (int c = 0; c < NC; c++) begin
                cfg_p[c] = pool[$urandom_range(0, 4)];
                cfg_e[c] = 1'($urandom);
            end
            apply_cfg();
            send_frame(pool[$urandom_range(0, 4)], $urandom_range(1, 8),
                       1'($urandom), 1'b0, 1'b0);
        end
        set_default_cfg();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_route();
        test_drop();
        test_disabled();
        test_backpressure();
        test_back_to_back();
        test_cfg_change();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ip_proto_dispatch.md
IP_PROTO_DISPATCH -- requirements
Module: ip_proto_dispatch

Interface
REQ-001 Parameter NUM_CH, default 4: number of output protocol channels, range 1..16.
REQ-002 Parameter DATA_WIDTH, default 8: payload tdata width in bits.
REQ-003 Parameter CNT_WIDTH, default 16: width of each statistics counter.
REQ-004 i_clk  in  1  sole clock; all logic is on the rising edge.
REQ-005 i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 s_hdr_valid / s_hdr_ready  in/out  1/1  upstream IP header handshake.
REQ-007 s_ip_protocol, s_ip_length, s_ip_source_ip, s_ip_dest_ip  in  8/16/32/32  upstream header fields.
REQ-008 s_tdata, s_tvalid, s_tready, s_tlast, s_tuser  in/in/out/in/in  DATA_WIDTH/1/1/1/1  upstream payload stream.
REQ-009 m_hdr_valid / m_hdr_ready  out/in  NUM_CH/NUM_CH  per-channel header handshake.
REQ-010 m_ip_protocol, m_ip_length, m_ip_source_ip, m_ip_dest_ip  out  8/16/32/32  registered header fields, shared by all channels.
REQ-011 m_tdata, m_tlast, m_tuser  out  DATA_WIDTH/1/1  shared payload data; m_tvalid / m_tready  out/in  NUM_CH/NUM_CH.
REQ-012 cfg_proto  in  8*NUM_CH  protocol number per channel; cfg_en  in  NUM_CH  per-channel enable.
REQ-013 stat_clr  in  1  counter clear; stat_frames  out  CNT_WIDTH*NUM_CH; stat_drops  out  CNT_WIDTH.

Function
- REQ-014 FSM states are IDLE, HDR, PAYLOAD and DROP; s_hdr_ready SHALL be 1 only in IDLE.
- REQ-015 On an IDLE header handshake, the block SHALL latch all header fields and the select, then move to HDR on the next cycle.
- REQ-016 Select SHALL be the lowest channel index i with cfg_en[i]=1 and cfg_proto[i]=s_ip_protocol.
- REQ-017 When no channel matches, the block SHALL go to DROP instead of HDR and increment stat_drops.
- REQ-018 In HDR, only m_hdr_valid[sel] SHALL be 1; on m_hdr_ready[sel] the block SHALL go to PAYLOAD.
- REQ-019 The header path has 1-cycle latency: m_hdr_valid is asserted in the cycle after s_hdr handshake.
- REQ-020 In PAYLOAD, the payload SHALL pass through combinationally: m_tvalid[sel]=s_tvalid, s_tready=m_tready[sel], data/last/user pass straight through.
- REQ-021 All other m_tvalid bits SHALL be 0.
- REQ-022 A handshake with s_tlast=1 in PAYLOAD SHALL increment stat_frames[sel] and return the FSM to IDLE.
- REQ-023 In DROP, s_tready SHALL be 1 and all m_tvalid SHALL be 0; a handshake with s_tlast=1 SHALL return the FSM to IDLE.
- REQ-024 cfg_proto and cfg_en changes SHALL affect only frames whose header is accepted after the change.
- REQ-025 Counters SHALL saturate at all-ones.
- REQ-026 stat_clr SHALL zero all counters next cycle and SHALL win over a simultaneous increment.
- REQ-027 A one-beat payload (tlast on first beat) SHALL be handled without extra idle cycles beyond the HDR state.

Reset
- REQ-028 Asserting i_rst_n low at any time, including mid-frame, SHALL force IDLE and clear all counters.
- REQ-029 During reset, all m_hdr_valid, m_tvalid and s_tready outputs SHALL be 0, and registered header outputs SHALL be 0.
- REQ-030 After reset deassertion, s_hdr_ready SHALL be 1 on the first clock edge.

Configuration
- REQ-031 With IP_DISPATCH_STATS_EN defined, the stat_frames and stat_drops counters are implemented as specified.
- REQ-032 Without IP_DISPATCH_STATS_EN, stat_frames and stat_drops SHALL be tied to 0, stat_clr is ignored, and no counter flops exist; routing behaviour is identical.

Structure
- REQ-033 Package ip_dispatch_pkg SHALL hold the FSM state enum and the constants PROTO_ICMP=8'h01, PROTO_TCP=8'h06 and PROTO_UDP=8'h11.
- REQ-034 Sub-module ip_dispatch_match SHALL implement the priority match, with outputs hit and sel index of width $clog2(NUM_CH), minimum 1.

Verification
- REQ-035 Channel table {1,0x11,6,0x11}, all enabled; header protocol 0x11 with 4-byte payload -> channel 1 only; stat_frames[1]=1.
- REQ-036 Header protocol 0x2F (no match) with 10-byte payload -> all 10 bytes consumed; no m_tvalid asserted; stat_drops=1; IDLE afterwards.
- REQ-037 Channel 1 disabled, protocol 0x11 -> routed to channel 3.
- REQ-038 m_tready[sel] toggling 50% -> byte order and count preserved.
- REQ-039 Reset mid-payload -> outputs 0; the next frame routes correctly.
- REQ-040 CNT_WIDTH=4 with 17 frames -> count saturates at 15; stat_clr coincident with tlast -> count 0.
- REQ-041 Build without IP_DISPATCH_STATS_EN -> counters read 0; routing results identical to the REQ-035 case.
